avg_sample_buffer: RTL and testbench



---
 rtl/avg_pkg.sv | 15 +
 rtl/avg_sample_ram.sv | 34 +++
 rtl/avg_sample_buffer.sv | 134 +++++++++++++
 tb/tb_avg_sample_buffer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/avg_pkg.sv
// Shared constants and FSM state type for the sample buffer and the averager it feeds.
package avg_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned DEPTH  = 1023;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    LAUNCH    = 2'd1,
    STREAM    = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/avg_sample_ram.sv
// Single-port sample store: synchronous write, one-cycle registered read.
// The read register doubles as the replay output, so it is reset and holds when idle.
module avg_sample_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 1023,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array carries no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/avg_sample_buffer.sv
// Collects a frame of samples into local RAM, then replays it to the averager as
// start pulse + sample count + one sample per clock, and waits for done.
module avg_sample_buffer #(
  parameter int unsigned DATA_W = avg_pkg::DATA_W,
  parameter int unsigned CNT_W  = avg_pkg::CNT_W,
  parameter int unsigned DEPTH  = avg_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_start,
  output logic [CNT_W-1:0]  out_num,
  output logic [DATA_W-1:0] out_data,
  input  logic              avg_done,
  output logic              busy
);

  import avg_pkg::state_e, avg_pkg::FILL, avg_pkg::LAUNCH, avg_pkg::STREAM, avg_pkg::WAIT_DONE;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   out_num_d;
  logic               out_start_d;
  logic               in_ready_d;
  logic               busy_d;
  logic [CNT_W-1:0]   wr_inc_c;
  logic               fire_c;
  logic               ram_we_c;
  logic               ram_re_c;
  logic [CNT_W-1:0]   ram_addr_c;

  assign fire_c   = in_valid && in_ready && (state_q == FILL);
  assign wr_inc_c = wr_cnt_q + ONE_C;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      out_num   <= '0;
      out_start <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      out_num   <= out_num_d;
      out_start <= out_start_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
    end
  end

  // Next-state, counter and RAM control logic.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_num_d   = out_num;
    out_start_d = 1'b0;
    in_ready_d  = in_ready;
    busy_d      = busy;
    ram_we_c    = 1'b0;
    ram_re_c    = 1'b0;
    ram_addr_c  = wr_cnt_q;

    unique case (state_q)
      FILL: begin
        if (fire_c) begin
          ram_we_c = 1'b1;
          wr_cnt_d = wr_inc_c;
          // in_last and the DEPTH limit landing together still close only once.
          if (in_last || (wr_inc_c == DEPTH_C)) begin
            out_num_d   = wr_inc_c;
            out_start_d = 1'b1;
            in_ready_d  = 1'b0;
            busy_d      = 1'b1;
            state_d     = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        ram_addr_c = '0;
        ram_re_c   = 1'b1;
        rd_cnt_d   = ONE_C;
        state_d    = STREAM;
      end
      STREAM: begin
        ram_addr_c = rd_cnt_q;
        if (rd_cnt_q == out_num) begin
          state_d = WAIT_DONE;
        end else begin
          ram_re_c = 1'b1;
          rd_cnt_d = rd_cnt_q + ONE_C;
        end
      end
      WAIT_DONE: begin
        if (avg_done) begin
          wr_cnt_d   = '0;
          busy_d     = 1'b0;
          in_ready_d = 1'b1;
          state_d    = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  avg_sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (CNT_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we_c),
    .re    (ram_re_c),
    .addr  (ram_addr_c),
    .wdata (in_data),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_avg_sample_buffer.sv
// Directed bench for avg_sample_buffer: table of small frames plus hand-written
// sequences for the DEPTH auto-close, early avg_done and reset mid-stream.
module tb_avg_sample_buffer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned DEPTH  = 1023;
  localparam int          TMO    = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              out_start;
  logic [CNT_W-1:0]  out_num;
  logic [DATA_W-1:0] out_data;
  logic              avg_done;
  logic              busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] frame [DEPTH];

  typedef struct {
    int         n;
    bit         use_last;
    bit         gaps;
    logic [7:0] d [8];
    int         exp_num;
    int         exp_avg;
  } vec_t;

  vec_t tbl [4];

  avg_sample_buffer #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_start (out_start),
    .out_num   (out_num),
    .out_data  (out_data),
    .avg_done  (avg_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Offer frame[0..n-1]; inputs change on negedges, transfers happen on posedges.
  task automatic fill(input int n, input bit use_last, input bit gaps, input bit hold);
    int w;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          in_last  = 1'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = frame[i];
      in_last  = use_last && (i == n - 1);
      w = 0;
      while (!in_ready && w < TMO) begin
        @(negedge clk);
        w++;
      end
      if (w >= TMO) begin
        chk($sformatf("fill_stall[%0d]", i), w, 0);
        break;
      end
      @(negedge clk);
    end
    in_last = 1'b0;
    in_data = 8'h00;
    if (!hold) in_valid = 1'b0;
  endtask

  // Called in the cycle after the closing transfer; plays the averager's side.
  task automatic stream(input int n, input int exp_avg, input bit done_early);
    int w;
    int sum;
    w = 0;
    while (!out_start && w < TMO) begin
      @(negedge clk);
      w++;
    end
    chk("start_delay", w, 0);
    chk("out_num", int'(out_num), n);
    chk("busy_launch", int'(busy), 1);
    chk("ready_launch", int'(in_ready), 0);
    if (done_early) avg_done = 1'b1;
    sum = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("out_data[%0d]", k), int'(out_data), int'(frame[k]));
      if (k == 0) chk("start_pulse_len", int'(out_start), 0);
      sum += int'(out_data);
    end
    @(negedge clk);
    avg_done = 1'b0;
    chk("hold_last", int'(out_data), int'(frame[n-1]));
    chk("busy_wait", int'(busy), 1);
    if (done_early) begin
      repeat (3) begin
        @(negedge clk);
        chk("early_done_ready", int'(in_ready), 0);
        chk("early_done_busy", int'(busy), 1);
      end
    end
    @(negedge clk);
    chk("ready_before_done", int'(in_ready), 0);
    chk("out_num_held", int'(out_num), n);
    avg_done = 1'b1;
    @(negedge clk);
    avg_done = 1'b0;
    chk("ready_after_done", int'(in_ready), 1);
    chk("busy_after_done", int'(busy), 0);
    chk("avg", sum / n, exp_avg);
  endtask

  initial begin
    tbl[0].n = 4; tbl[0].use_last = 1'b1; tbl[0].gaps = 1'b0;
    tbl[0].d = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd0, 8'd0, 8'd0, 8'd0};
    tbl[0].exp_num = 4; tbl[0].exp_avg = 25;
    tbl[1].n = 1; tbl[1].use_last = 1'b1; tbl[1].gaps = 1'b0;
    tbl[1].d = '{8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    tbl[1].exp_num = 1; tbl[1].exp_avg = 200;
    tbl[2].n = 8; tbl[2].use_last = 1'b1; tbl[2].gaps = 1'b1;
    tbl[2].d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    tbl[2].exp_num = 8; tbl[2].exp_avg = 4;
    tbl[3].n = 5; tbl[3].use_last = 1'b1; tbl[3].gaps = 1'b1;
    tbl[3].d = '{8'd0, 8'd255, 8'd128, 8'd1, 8'd2, 8'd0, 8'd0, 8'd0};
    tbl[3].exp_num = 5; tbl[3].exp_avg = 77;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    avg_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_start", int'(out_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_num", int'(out_num), 0);
    chk("rst_out_data", int'(out_data), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);

    // Avg_done outside WAIT_DONE must not disturb an idle buffer.
    avg_done = 1'b1;
    @(negedge clk);
    avg_done = 1'b0;
    chk("idle_done_busy", int'(busy), 0);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < tbl[t].n; i++) frame[i] = tbl[t].d[i];
      fill(tbl[t].n, tbl[t].use_last, tbl[t].gaps, 1'b0);
      stream(tbl[t].exp_num, tbl[t].exp_avg, 1'b0);
    end

    // DEPTH auto-close with no in_last; the next offered sample is held off.
    for (int i = 0; i < int'(DEPTH); i++) frame[i] = 8'hFF;
    fill(int'(DEPTH), 1'b0, 1'b0, 1'b1);
    chk("depth_holdoff_ready", int'(in_ready), 0);
    stream(int'(DEPTH), 255, 1'b0);

    // Avg_done held high through LAUNCH and STREAM is ignored.
    frame[0] = 8'd3; frame[1] = 8'd6; frame[2] = 8'd9;
    fill(3, 1'b1, 1'b0, 1'b0);
    stream(3, 6, 1'b1);

    // Reset mid-STREAM of a 50-sample frame abandons it.
    for (int i = 0; i < 50; i++) frame[i] = 8'(i + 1);
    fill(50, 1'b1, 1'b0, 1'b0);
    chk("pre_reset_start", int'(out_start), 1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_start", int'(out_start), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_num", int'(out_num), 0);
    chk("midrst_out_data", int'(out_data), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 1);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_restart", int'(out_start), 0);
      chk("midrst_data_idle", int'(out_data), 0);
    end

    frame[0] = 8'd7; frame[1] = 8'd8; frame[2] = 8'd9;
    fill(3, 1'b1, 1'b0, 1'b0);
    stream(3, 8, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
